// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller.
// Holds the state codes, the one-hot lamp encodings, and helpers that map a
// state to its lamp pattern and to its successor in the normal cycle.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  // Returns {ns_lamp, ew_lamp}. FLASH gives its entry pattern; the toggling
  // is handled by the controller.
  function automatic logic [5:0] lamps_for(input state_t s);
    case (s)
      NS_G:    lamps_for = {GREEN, RED};
      NS_Y:    lamps_for = {YELLOW, RED};
      EW_G:    lamps_for = {RED, GREEN};
      EW_Y:    lamps_for = {RED, YELLOW};
      FLASH:   lamps_for = {YELLOW, RED};
      default: lamps_for = {RED, RED};
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      AR2:     next_phase = NS_G;
      NS_G:    next_phase = NS_Y;
      NS_Y:    next_phase = AR1;
      AR1:     next_phase = EW_G;
      EW_G:    next_phase = EW_Y;
      EW_Y:    next_phase = AR2;
      default: next_phase = AR2;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick strobe every PRESCALE cycles.
// Ports: clk (clock), rst (async active-low reset), tick (strobe, high while
// the internal counter sits at PRESCALE-1).
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
    end
  endgenerate

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way (NS/EW) intersection controller with per-phase tick timing,
// optional vehicle-actuated green rest and a maintenance flash mode.
// Ports: clk, rst (async active-low), ns_req/ew_req (level requests),
// flash_en (maintenance flash), NS_light/EW_light (one-hot lamps),
// state_out (state code), clk_count (ticks remaining in phase).
//
// state | meaning
// NS_G  | NS green, EW red
// NS_Y  | NS yellow, EW red
// AR1   | all red, clearing NS before EW green
// EW_G  | EW green, NS red
// EW_Y  | EW yellow, NS red
// AR2   | all red, clearing EW before NS green (reset state)
// FLASH | NS yellow / EW red blinking together, timer parked at 0
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int PRESCALE     = 1,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int ACTUATED     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ns_req,
  input  logic             ew_req,
  input  logic             flash_en,
  output logic [2:0]       NS_light,
  output logic [2:0]       EW_light,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] clk_count
);

  generate
    if (GREEN_TICKS < 1 || GREEN_TICKS >= (1 << CNT_W)) begin : g_bad_green
      $error("traffic_light_ctrl: GREEN_TICKS out of range");
    end
    if (YELLOW_TICKS < 1 || YELLOW_TICKS >= (1 << CNT_W)) begin : g_bad_yellow
      $error("traffic_light_ctrl: YELLOW_TICKS out of range");
    end
    if (ALLRED_TICKS < 1 || ALLRED_TICKS >= (1 << CNT_W)) begin : g_bad_allred
      $error("traffic_light_ctrl: ALLRED_TICKS out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] G_T  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] Y_T  = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] AR_T = CNT_W'(ALLRED_TICKS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      NS_G, EW_G: dur = G_T;
      NS_Y, EW_Y: dur = Y_T;
      default:    dur = AR_T;
    endcase
  endfunction

  logic tick;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       ns_nxt, ew_nxt;
  logic             ns_pend, ew_pend, ns_pend_nxt, ew_pend_nxt;
  logic             rest_hold;

  // Actuated green rests on its last tick until the other direction asks.
  assign rest_hold = (ACTUATED != 0) &&
                     ((state == NS_G && !ew_pend) || (state == EW_G && !ns_pend));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= AR2;
      clk_count <= AR_T;
      NS_light  <= RED;
      EW_light  <= RED;
      ns_pend   <= 1'b0;
      ew_pend   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_count <= cnt_nxt;
      NS_light  <= ns_nxt;
      EW_light  <= ew_nxt;
      ns_pend   <= ns_pend_nxt;
      ew_pend   <= ew_pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = clk_count;
    ns_nxt      = NS_light;
    ew_nxt      = EW_light;
    ns_pend_nxt = ns_pend;
    ew_pend_nxt = ew_pend;

    if (flash_en) begin
      if (state != FLASH) begin
        state_nxt = FLASH;
        cnt_nxt   = '0;
      end
    end else if (state == FLASH) begin
      state_nxt = AR2;
      cnt_nxt   = AR_T;
    end else if (tick) begin
      if (clk_count == ONE) begin
        if (!rest_hold) begin
          state_nxt = next_phase(state);
          cnt_nxt   = dur(state_nxt);
        end
      end else begin
        cnt_nxt = clk_count - ONE;
      end
    end

    // Lamps follow the next state, except while staying in FLASH where
    // both heads blink together on each tick.
    if (state_nxt == FLASH && state == FLASH) begin
      if (tick) begin
        ns_nxt = (NS_light == DARK) ? YELLOW : DARK;
        ew_nxt = (EW_light == DARK) ? RED : DARK;
      end
    end else begin
      {ns_nxt, ew_nxt} = lamps_for(state_nxt);
    end

    // Pending flags freeze in FLASH; entry into a green clears its own flag.
    if (state != FLASH) begin
      if (ns_req && state != NS_G) ns_pend_nxt = 1'b1;
      if (ew_req && state != EW_G) ew_pend_nxt = 1'b1;
      if (state_nxt == NS_G && state != NS_G) ns_pend_nxt = 1'b0;
      if (state_nxt == EW_G && state != EW_G) ew_pend_nxt = 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: three instances (defaults, PRESCALE=4,
// ACTUATED=1) share clock, reset and inputs. A phase-table model predicts
// every output each cycle; directed literal checks pin the model.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst, ns_req, ew_req, flash_en;

  logic [2:0] dns [3];
  logic [2:0] dew [3];
  logic [2:0] dst [3];
  logic [7:0] dcc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl u_def (
    .clk(clk), .rst(rst), .ns_req(ns_req), .ew_req(ew_req), .flash_en(flash_en),
    .NS_light(dns[0]), .EW_light(dew[0]), .state_out(dst[0]), .clk_count(dcc[0])
  );

  traffic_light_ctrl #(.PRESCALE(4)) u_pre (
    .clk(clk), .rst(rst), .ns_req(ns_req), .ew_req(ew_req), .flash_en(flash_en),
    .NS_light(dns[1]), .EW_light(dew[1]), .state_out(dst[1]), .clk_count(dcc[1])
  );

  traffic_light_ctrl #(.ACTUATED(1)) u_act (
    .clk(clk), .rst(rst), .ns_req(ns_req), .ew_req(ew_req), .flash_en(flash_en),
    .NS_light(dns[2]), .EW_light(dew[2]), .state_out(dst[2]), .clk_count(dcc[2])
  );

  // ---------------- model ----------------
  int         prs [3]    = '{1, 4, 1};
  bit         act [3]    = '{1'b0, 1'b0, 1'b1};
  int         dur_tab [6] = '{10, 3, 1, 10, 3, 1};
  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_ph [3];
  int m_cnt [3];
  int m_pre [3];
  bit m_fl [3];
  bit m_dark [3];
  bit m_np [3];
  bit m_ep [3];

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 5; m_cnt[i] = dur_tab[5]; m_pre[i] = 0;
      m_fl[i] = 0; m_dark[i] = 0; m_np[i] = 0; m_ep[i] = 0;
    end
  endtask

  task automatic m_step(input bit nsr, input bit ewr, input bit fl);
    for (int i = 0; i < 3; i++) begin
      bit tk;
      int oldph;
      bit oldfl, onp, oep;
      tk    = (m_pre[i] == prs[i] - 1);
      m_pre[i] = tk ? 0 : m_pre[i] + 1;
      oldph = m_ph[i]; oldfl = m_fl[i]; onp = m_np[i]; oep = m_ep[i];
      if (fl) begin
        if (!oldfl) begin m_fl[i] = 1; m_dark[i] = 0; m_cnt[i] = 0; end
        else if (tk) m_dark[i] = !m_dark[i];
      end else if (oldfl) begin
        m_fl[i] = 0; m_ph[i] = 5; m_cnt[i] = dur_tab[5];
      end else if (tk) begin
        if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
        else if (!(act[i] && ((oldph == 0 && !oep) || (oldph == 3 && !onp)))) begin
          m_ph[i]  = (m_ph[i] + 1) % 6;
          m_cnt[i] = dur_tab[m_ph[i]];
        end
      end
      if (!oldfl) begin
        if (nsr && oldph != 0) m_np[i] = 1;
        if (ewr && oldph != 3) m_ep[i] = 1;
        if (!m_fl[i] && m_ph[i] == 0 && oldph != 0) m_np[i] = 0;
        if (!m_fl[i] && m_ph[i] == 3 && oldph != 3) m_ep[i] = 0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step(ns_req, ew_req, flash_en);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int prev_st [3] = '{5, 5, 5};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int es;
        logic [2:0] en, ee;
        es = m_fl[i] ? 6 : m_ph[i];
        en = m_fl[i] ? (m_dark[i] ? 3'b000 : 3'b010) : ns_tab[m_ph[i]];
        ee = m_fl[i] ? (m_dark[i] ? 3'b000 : 3'b100) : ew_tab[m_ph[i]];
        chk($sformatf("state[%0d]", i), int'(dst[i]), es);
        chk($sformatf("count[%0d]", i), int'(dcc[i]), m_cnt[i]);
        chk($sformatf("ns_lamp[%0d]", i), int'(dns[i]), int'(en));
        chk($sformatf("ew_lamp[%0d]", i), int'(dew[i]), int'(ee));
        chk($sformatf("dual_green[%0d]", i), int'(dns[i] == 3'b001 && dew[i] == 3'b001), 0);
        if (dst[i] == 3'd0 && prev_st[i] != 0)
          chk($sformatf("ns_green_after_allred[%0d]", i), prev_st[i], 5);
        if (dst[i] == 3'd3 && prev_st[i] != 3)
          chk($sformatf("ew_green_after_allred[%0d]", i), prev_st[i], 2);
        prev_st[i] = int'(dst[i]);
      end
    end
  end

  task automatic wait_state(input int i, input int s);
    int n = 0;
    while (int'(dst[i]) != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_state%0d[%0d]", s, i), int'(dst[i]), s);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; ns_req = 1'b0; ew_req = 1'b0; flash_en = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(dst[0]), 5);
    chk("reset_count", int'(dcc[0]), 1);
    chk("reset_ns", int'(dns[0]), 4);
    chk("reset_ew", int'(dew[0]), 4);
    rst = 1'b1;

    @(negedge clk);
    chk("first_ns_g", int'(dst[0]), 0);
    chk("first_ns_g_count", int'(dcc[0]), 10);
    chk("pre4_still_ar2_e1", int'(dst[1]), 5);
    repeat (2) @(negedge clk);
    chk("pre4_still_ar2_e3", int'(dst[1]), 5);
    @(negedge clk);
    chk("pre4_ns_g_e4", int'(dst[1]), 0);
    chk("pre4_ns_g_count", int'(dcc[1]), 10);
    repeat (24) @(negedge clk);
    chk("period_ar2_e28", int'(dst[0]), 5);
    @(negedge clk);
    chk("period_ns_g_e29", int'(dst[0]), 0);
    chk("period_ns_g_count", int'(dcc[0]), 10);
    chk("act_rest_state", int'(dst[2]), 0);
    chk("act_rest_count", int'(dcc[2]), 1);

    ew_req = 1'b1;
    @(negedge clk);
    ew_req = 1'b0;
    @(negedge clk);
    chk("act_to_ns_y", int'(dst[2]), 1);
    repeat (4) @(negedge clk);
    chk("act_to_ew_g", int'(dst[2]), 3);
    chk("act_ew_g_count", int'(dcc[2]), 10);

    wait_state(0, 3);
    repeat (2) @(negedge clk);
    flash_en = 1'b1;
    @(negedge clk);
    chk("flash_state", int'(dst[0]), 6);
    chk("flash_count", int'(dcc[0]), 0);
    chk("flash_ns_on", int'(dns[0]), 2);
    chk("flash_ew_on", int'(dew[0]), 4);
    @(negedge clk);
    chk("flash_ns_off", int'(dns[0]), 0);
    chk("flash_ew_off", int'(dew[0]), 0);
    repeat (6) @(negedge clk);
    flash_en = 1'b0;
    @(negedge clk);
    chk("unflash_state", int'(dst[0]), 5);
    chk("unflash_count", int'(dcc[0]), 1);
    chk("unflash_ns", int'(dns[0]), 4);
    chk("unflash_ew", int'(dew[0]), 4);
    @(negedge clk);
    chk("unflash_ns_g", int'(dst[0]), 0);

    wait_state(0, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", int'(dst[0]), 5);
    chk("async_rst_count", int'(dcc[0]), 1);
    chk("async_rst_ns", int'(dns[0]), 4);
    chk("async_rst_ew", int'(dew[0]), 4);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
